alu_mdu: RTL

- Parametrised, handshaked execute unit; successor to the single-cycle combinational ALU.
- Covers the base integer ops plus the RV M-extension (MUL/MULH*/DIV*/REM*), using an iterative shift-add multiplier and a restoring divider.
- Sits in the execute stage; the core stalls on in_ready/out_valid instead of assuming single-cycle results.

---
 rtl/alu_mdu.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/alu_mdu.sv
// alu_mdu: handshaked execute unit with single-cycle base integer ops and
// RV M-extension multiply/divide via iterative shift-add and restoring division.
module alu_mdu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            busy
);
    localparam int SHW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [SHW-1:0]  LAST_CNT = SHW'(XLEN-1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            stateQ;
    logic [2:0]        mOpQ;
    logic              negResQ;
    logic              negRemQ;
    logic [XLEN-1:0]   magBQ;
    logic [XLEN-1:0]   remQ;
    logic [XLEN-1:0]   resultQ;
    logic [2*XLEN-1:0] accQ;
    logic [SHW-1:0]    cntQ;
    logic              zeroQ;

    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] baseRes;

    always_comb begin
        shamt   = src_b[SHW-1:0];
        baseRes = '0;
        case (op[3:0])
            4'b0000: baseRes = src_a & src_b;
            4'b0001: baseRes = src_a | src_b;
            4'b0010: baseRes = src_a + src_b;
            4'b0110: baseRes = src_a - src_b;
            4'b1100: baseRes = ~(src_a | src_b);
            4'b1010: baseRes = src_a ^ src_b;
            4'b0111: baseRes = XLEN'($signed(src_a) < $signed(src_b));
            4'b1111: baseRes = XLEN'(src_a < src_b);
            4'b1110: baseRes = XLEN'(src_a == src_b);
            4'b1011: baseRes = XLEN'($signed(src_a) >= $signed(src_b));
            4'b1101: baseRes = XLEN'(src_a >= src_b);
            4'b1000: baseRes = src_a << shamt;
            4'b1001: baseRes = src_a >> shamt;
            4'b0011: baseRes = $signed(src_a) >>> shamt;
            default: baseRes = '0;
        endcase
    end

    logic            isMul;
    logic            isDiv;
    logic            signA;
    logic            signB;
    logic            negA;
    logic            negB;
    logic            divZero;
    logic            divOvf;
    logic [XLEN-1:0] magA;
    logic [XLEN-1:0] magB;
    logic [XLEN-1:0] quickRes;

    // Decode at accept: operand magnitudes plus the cases resolved without iterating.
    always_comb begin
        isMul   = op[4] & ~op[3] & ~op[2];
        isDiv   = op[4] & ~op[3] & op[2];
        signA   = isMul ? (op[1:0] == 2'b01 || op[1:0] == 2'b10) : ~op[0];
        signB   = isMul ? (op[1:0] == 2'b01) : ~op[0];
        negA    = signA & src_a[XLEN-1];
        negB    = signB & src_b[XLEN-1];
        magA    = negA ? -src_a : src_a;
        magB    = negB ? -src_b : src_b;
        divZero = isDiv && (src_b == '0);
        divOvf  = isDiv && !op[0] && (src_a == MOST_NEG) && (src_b == '1);
        if (!op[4]) begin
            quickRes = baseRes;
        end else if (divZero) begin
            quickRes = op[1] ? src_a : '1;
        end else if (divOvf) begin
            quickRes = op[1] ? '0 : MOST_NEG;
        end else begin
            quickRes = '0;
        end
    end

    logic [XLEN:0]     mulSum;
    logic [XLEN:0]     remShift;
    logic [XLEN:0]     remDiff;
    logic              divFits;
    logic [XLEN-1:0]   remD;
    logic [XLEN-1:0]   quoD;
    logic [XLEN-1:0]   quoFinal;
    logic [XLEN-1:0]   remFinal;
    logic [XLEN-1:0]   finalRes;
    logic [2*XLEN-1:0] mulAccD;
    logic [2*XLEN-1:0] prodFinal;

    // The low half of accQ holds the multiplier (mul) or the dividend/quotient (div).
    always_comb begin
        mulSum    = {1'b0, accQ[2*XLEN-1:XLEN]} + (accQ[0] ? {1'b0, magBQ} : '0);
        mulAccD   = {mulSum, accQ[XLEN-1:1]};
        remShift  = {remQ, accQ[XLEN-1]};
        remDiff   = remShift - {1'b0, magBQ};
        divFits   = remShift[XLEN] | ~remDiff[XLEN];
        remD      = divFits ? remDiff[XLEN-1:0] : remShift[XLEN-1:0];
        quoD      = {accQ[XLEN-2:0], divFits};
        prodFinal = negResQ ? -mulAccD : mulAccD;
        quoFinal  = negResQ ? -quoD : quoD;
        remFinal  = negRemQ ? -remD : remD;
        if (mOpQ[2]) begin
            finalRes = mOpQ[1] ? remFinal : quoFinal;
        end else begin
            finalRes = (mOpQ[1:0] == 2'b00) ? prodFinal[XLEN-1:0] : prodFinal[2*XLEN-1:XLEN];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stateQ  <= IDLE;
            mOpQ    <= '0;
            negResQ <= 1'b0;
            negRemQ <= 1'b0;
            magBQ   <= '0;
            remQ    <= '0;
            accQ    <= '0;
            cntQ    <= '0;
            resultQ <= '0;
            zeroQ   <= 1'b1;
        end else if (flush) begin
            stateQ <= IDLE;
        end else begin
            case (stateQ)
                IDLE: begin
                    if (in_valid) begin
                        mOpQ <= op[2:0];
                        if ((isMul || isDiv) && !divZero && !divOvf) begin
                            negResQ <= negA ^ negB;
                            negRemQ <= negA;
                            magBQ   <= magB;
                            accQ    <= {{XLEN{1'b0}}, magA};
                            remQ    <= '0;
                            cntQ    <= '0;
                            stateQ  <= BUSY;
                        end else begin
                            resultQ <= quickRes;
                            zeroQ   <= (quickRes == '0);
                            stateQ  <= DONE;
                        end
                    end
                end
                BUSY: begin
                    cntQ <= cntQ + 1'b1;
                    if (mOpQ[2]) begin
                        accQ <= {{XLEN{1'b0}}, quoD};
                        remQ <= remD;
                    end else begin
                        accQ <= mulAccD;
                    end
                    if (cntQ == LAST_CNT) begin
                        resultQ <= finalRes;
                        zeroQ   <= (finalRes == '0);
                        stateQ  <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        stateQ <= IDLE;
                    end
                end
                default: stateQ <= IDLE;
            endcase
        end
    end

    assign in_ready  = (stateQ == IDLE);
    assign out_valid = (stateQ == DONE);
    assign busy      = (stateQ == BUSY);
    assign result    = resultQ;
    assign zero      = zeroQ;

endmodule
